// File: rtl/cl_pkg.sv
// Shared definitions for the logic-cell identification engine: select codes,
// the truth table each select code produces, and the scan FSM encoding.
package cl_pkg;

    // Select codes understood by the 2-input logic cell
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    // Truth tables indexed by {a,b}; bit 0 is the result for a=0,b=0
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NOTA = 4'b0011;

    // Number of (a,b) stimulus vectors in one scan
    localparam int unsigned NUM_VECTORS = 4;

    // Index of the final stimulus vector
    localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

    // Scan controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DRIVE  = 2'b01,
        ST_DECODE = 2'b10
    } state_e;

endpackage

// File: rtl/cl_tt_decode.sv
// Maps a captured 4-bit truth table back to the logic-cell select code that
// produces it. Unknown tables report no match and a select code of AND.
module cl_tt_decode
    import cl_pkg::*;
(
    input  logic [3:0] tt_i,
    output logic [1:0] op_o,
    output logic       match_o
);

    // Compare the table against the four known cell functions
    always_comb begin
        op_o    = OP_AND;
        match_o = 1'b0;
        case (tt_i)
            TT_AND: begin
                op_o    = OP_AND;
                match_o = 1'b1;
            end
            TT_OR: begin
                op_o    = OP_OR;
                match_o = 1'b1;
            end
            TT_XOR: begin
                op_o    = OP_XOR;
                match_o = 1'b1;
            end
            TT_NOTA: begin
                op_o    = OP_NOTA;
                match_o = 1'b1;
            end
            default: begin
                op_o    = OP_AND;
                match_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cl_identify.sv
// Identification engine for the 2-input logic cell. It walks {a,b} through
// 00,01,10,11, holds each vector for SETTLE cycles, samples the cell output on
// the last cycle of each hold, then decodes the resulting truth table.
module cl_identify
    import cl_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       out_in,
    output logic       busy,
    output logic       done,
    output logic [1:0] op,
    output logic       match,
    output logic [3:0] tt
);

    // Settle counter value on which the cell output is sampled
    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] op_q, op_d;
    logic       match_q, match_d;
    logic [3:0] tt_q, tt_d;

    logic [1:0] dec_op;
    logic       dec_match;

    cl_tt_decode u_decode (
        .tt_i    (tt_q),
        .op_o    (dec_op),
        .match_o (dec_match)
    );

    // Next-state logic: start handling, vector stepping, sampling and decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        op_d    = op_q;
        match_d = match_q;
        tt_d    = tt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    tt_d    = 4'b0000;
                end
            end

            ST_DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = 4'd0;
                    tt_d[idx_q] = out_in;
                    if (idx_q != LAST_IDX) begin
                        idx_d      = idx_q + 2'd1;
                        {a_d, b_d} = idx_q + 2'd1;
                    end else begin
                        state_d = ST_DECODE;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end
                end
            end

            ST_DECODE: begin
                op_d    = dec_op;
                match_d = dec_match;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= OP_AND;
            match_q <= 1'b0;
            tt_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            op_q    <= op_d;
            match_q <= match_d;
            tt_q    <= tt_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign op    = op_q;
    assign match = match_q;
    assign tt    = tt_q;

endmodule

// File: tb/tb_cl_identify.sv
// Self-checking bench for cl_identify. One instance (SETTLE=1) drives a model
// of the logic cell; a second instance (SETTLE=3) sees a bench-driven out_in.
module tb_cl_identify;
    import cl_pkg::*;

    typedef struct {
        string      name;
        logic [1:0] sel;
        logic [3:0] expTt;
        logic [1:0] expOp;
        logic       expMatch;
    } vecT;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start;
    logic       start3;
    logic [1:0] cellSel;

    logic       a, b, outIn, busy, done, match;
    logic [1:0] op;
    logic [3:0] tt;

    logic       a3, b3, outIn3, busy3, done3, match3;
    logic [1:0] op3;
    logic [3:0] tt3;

    int testsRun    = 0;
    int testsFailed = 0;

    vecT vectors [4];

    always #5 clk = ~clk;

    // Behavioural model of the 2-input logic cell
    always_comb begin
        outIn = 1'b0;
        case (cellSel)
            2'b00: outIn = a & b;
            2'b01: outIn = a | b;
            2'b10: outIn = a ^ b;
            2'b11: outIn = ~a;
            default: outIn = 1'b0;
        endcase
    end

    cl_identify #(.SETTLE(1)) dut (
        .clk    (clk),
        .rst_n  (rstN),
        .start  (start),
        .a      (a),
        .b      (b),
        .out_in (outIn),
        .busy   (busy),
        .done   (done),
        .op     (op),
        .match  (match),
        .tt     (tt)
    );

    cl_identify #(.SETTLE(3)) dut3 (
        .clk    (clk),
        .rst_n  (rstN),
        .start  (start3),
        .a      (a3),
        .b      (b3),
        .out_in (outIn3),
        .busy   (busy3),
        .done   (done3),
        .op     (op3),
        .match  (match3),
        .tt     (tt3)
    );

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Full scan on the SETTLE=1 instance with positional latency checks
    task automatic applyStimulus(input vecT v);
        cellSel = v.sel;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({v.name, " busy after accept"}, 8'(busy), 8'd1);
        checkOutput({v.name, " tt cleared"}, 8'(tt), 8'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s ab step %0d", v.name, i), 8'({a, b}), 8'(i[1:0]));
            checkOutput($sformatf("%s done low %0d", v.name, i), 8'(done), 8'd0);
            @(negedge clk);
        end
        checkOutput({v.name, " ab back to 00"}, 8'({a, b}), 8'd0);
        checkOutput({v.name, " done before decode"}, 8'(done), 8'd0);
        checkOutput({v.name, " busy in decode"}, 8'(busy), 8'd1);
        @(negedge clk);
        checkOutput({v.name, " done pulse"}, 8'(done), 8'd1);
        checkOutput({v.name, " busy low at done"}, 8'(busy), 8'd0);
        checkOutput({v.name, " tt"}, 8'(tt), 8'(v.expTt));
        checkOutput({v.name, " op"}, 8'(op), 8'(v.expOp));
        checkOutput({v.name, " match"}, 8'(match), 8'(v.expMatch));
        @(negedge clk);
        checkOutput({v.name, " done cleared"}, 8'(done), 8'd0);
        checkOutput({v.name, " op held"}, 8'(op), 8'(v.expOp));
        checkOutput({v.name, " tt held"}, 8'(tt), 8'(v.expTt));
    endtask

    initial begin
        vectors[0] = '{name: "xor",  sel: 2'b10, expTt: 4'b0110, expOp: 2'b10, expMatch: 1'b1};
        vectors[1] = '{name: "and",  sel: 2'b00, expTt: 4'b1000, expOp: 2'b00, expMatch: 1'b1};
        vectors[2] = '{name: "or",   sel: 2'b01, expTt: 4'b1110, expOp: 2'b01, expMatch: 1'b1};
        vectors[3] = '{name: "nota", sel: 2'b11, expTt: 4'b0011, expOp: 2'b11, expMatch: 1'b1};

        rstN    = 1'b0;
        start   = 1'b0;
        start3  = 1'b0;
        outIn3  = 1'b0;
        cellSel = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset ab", 8'({a, b}), 8'd0);
        checkOutput("reset busy", 8'(busy), 8'd0);
        checkOutput("reset done", 8'(done), 8'd0);
        checkOutput("reset op", 8'(op), 8'd0);
        checkOutput("reset match", 8'(match), 8'd0);
        checkOutput("reset tt", 8'(tt), 8'd0);
        checkOutput("reset busy3", 8'(busy3), 8'd0);
        rstN = 1'b1;

        for (int k = 0; k < 4; k++) begin
            applyStimulus(vectors[k]);
        end

        // SETTLE=3 with a constant-1 cell; out_in is 0 except on sampling edges
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int j = 0; j < 13; j++) begin
            if (j < 12) begin
                checkOutput($sformatf("s3 ab after edge %0d", j), 8'({a3, b3}), 8'(j / 3));
            end
            checkOutput($sformatf("s3 done low %0d", j), 8'(done3), 8'd0);
            outIn3 = ((j + 1) % 3 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        checkOutput("s3 done pulse", 8'(done3), 8'd1);
        checkOutput("s3 busy low", 8'(busy3), 8'd0);
        checkOutput("s3 tt", 8'(tt3), 8'hf);
        checkOutput("s3 op", 8'(op3), 8'd0);
        checkOutput("s3 match", 8'(match3), 8'd0);
        outIn3 = 1'b0;

        // start held high for a whole scan, then still high in the done cycle
        cellSel = 2'b10;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b busy %0d", j), 8'(busy), 8'd1);
            checkOutput($sformatf("b2b done low %0d", j), 8'(done), 8'd0);
            if (j < 4) begin
                checkOutput($sformatf("b2b ab %0d", j), 8'({a, b}), 8'(j));
            end
        end
        @(negedge clk);
        checkOutput("b2b first done", 8'(done), 8'd1);
        checkOutput("b2b first tt", 8'(tt), 8'b0110);
        checkOutput("b2b first op", 8'(op), 8'd2);
        cellSel = 2'b01;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b done cleared", 8'(done), 8'd0);
        checkOutput("b2b busy restarted", 8'(busy), 8'd1);
        checkOutput("b2b tt cleared", 8'(tt), 8'd0);
        checkOutput("b2b op held", 8'(op), 8'd2);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
        end
        checkOutput("b2b second done", 8'(done), 8'd1);
        checkOutput("b2b second tt", 8'(tt), 8'b1110);
        checkOutput("b2b second op", 8'(op), 8'd1);
        checkOutput("b2b second match", 8'(match), 8'd1);

        // reset while vector idx=2 is being driven
        cellSel = 2'b11;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst mid ab is 10", 8'({a, b}), 8'd2);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("rst mid ab", 8'({a, b}), 8'd0);
        checkOutput("rst mid busy", 8'(busy), 8'd0);
        checkOutput("rst mid done", 8'(done), 8'd0);
        checkOutput("rst mid op", 8'(op), 8'd0);
        checkOutput("rst mid match", 8'(match), 8'd0);
        checkOutput("rst mid tt", 8'(tt), 8'd0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            checkOutput($sformatf("rst no done %0d", j), 8'(done), 8'd0);
            checkOutput($sformatf("rst stays idle %0d", j), 8'(busy), 8'd0);
        end
        applyStimulus(vectors[3]);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
